mx2_arbiter: RTL

Two-requester round-robin arbiter and output register that controls a `mx2` 2:1 multiplexer shared by two sources.
- Each requester offers a WIDTH-bit beat with a valid/grant handshake.
- The arbiter picks one requester and drives the mux select `sel`.
- The selected beat is registered onto a single downstream channel with valid/ready flow control.
- It sits between two producer blocks and one consumer, and is the only block allowed to drive the shared mux select.

---
 rtl/mx2_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mx2_arbiter.sv
// mx2_arbiter
//   Two-requester round-robin arbiter that owns the select of a shared 2:1
//   mux and registers the selected beat onto one valid/ready channel.
//
// Parameters
//   WIDTH      data width of both requesters and of the output
//   MAX_BURST  beats one requester may hold the grant back-to-back (1..15),
//              only meaningful when MX2_ARB_BURST_EN is defined
//
// Configuration macro
//   MX2_ARB_BURST_EN  defined: a requester keeps the grant for up to
//                     MAX_BURST consecutive beats before handing over.
//                     undefined: no burst counter, strict alternation.
//
// Ports
//   clk, reset      single clock, synchronous active-high reset
//   req0/d0/gnt0    requester 0 valid, data, accept
//   req1/d1/gnt1    requester 1 valid, data, accept
//   sel             registered mux select (0 = d0, 1 = d1)
//   y_valid/y       output register valid and data
//   y_ready         consumer accepts y this cycle
module mx2_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt1,
  output logic             sel,
  output logic             y_valid,
  output logic [WIDTH-1:0] y,
  input  logic             y_ready
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_burst_range
    $error("mx2_arbiter: MAX_BURST must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic   out_free;
  logic   xfer;
  logic   own_req;
  logic   oth_req;
  state_e oth_state;
  logic   burst_done;

`ifdef MX2_ARB_BURST_EN
  logic [3:0] cnt_q, cnt_d;

  // This transfer is the MAX_BURST-th beat of the current grant.
  assign burst_done = ((32'(cnt_q) + 32'd1) >= MAX_BURST);
`else
  assign burst_done = 1'b1;
`endif

  // Grants are combinational from the registered state, so they never
  // overlap and sel is already stable for the whole granted cycle.
  always_comb begin
    out_free = !y_valid_q || y_ready;
    gnt0     = (state_q == G0) && req0 && out_free;
    gnt1     = (state_q == G1) && req1 && out_free;
    xfer     = gnt0 || gnt1;
  end

  always_comb begin
    own_req   = (state_q == G1) ? req1 : req0;
    oth_req   = (state_q == G1) ? req0 : req1;
    oth_state = (state_q == G1) ? G0 : G1;

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? G0 : G1;
        end else if (req0) begin
          state_d = G0;
        end else if (req1) begin
          state_d = G1;
        end
      end
      G0, G1: begin
        if (xfer) begin
          // Hand over on the edge that completes the last beat of the burst.
          if (burst_done && oth_req) begin
            state_d = oth_state;
          end
        end else if (!own_req) begin
          state_d = oth_req ? oth_state : IDLE;
        end
        // own_req high but output blocked: hold the grant.
      end
      default: state_d = IDLE;
    endcase

    sel_d = (state_d == G1);
  end

`ifdef MX2_ARB_BURST_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (xfer) begin
      cnt_d = burst_done ? '0 : cnt_q + 4'd1;
    end
  end
`endif

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    last_d    = last_q;
    if (xfer) begin
      y_d       = sel_q ? d1 : d0;
      y_valid_d = 1'b1;
      last_d    = sel_q;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      y_valid_q <= 1'b0;
      y_q       <= '0;
`ifdef MX2_ARB_BURST_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      y_valid_q <= y_valid_d;
      y_q       <= y_d;
`ifdef MX2_ARB_BURST_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign sel     = sel_q;
  assign y_valid = y_valid_q;
  assign y       = y_q;

endmodule
